countdown_ctrl: RTL
===================

# countdown_ctrl

- Sequencer for the seconds-count datapath that drives the minutes/tens/units digit decoder.
- Holds an 8-bit remaining-seconds value `num` in the range 0..239, i.e. up to 3:59.
- The user sets the value in 10 s steps, then starts, pauses and clears a once-per-second countdown.
- Raises `done` and a blinking `alarm` at zero. `num` feeds the decoder input directly.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per one-second tick (≥2).
- `MAX_SEC`, 239: upper saturation limit for `num`.
- `STEP`, 10: seconds added or removed per up/down press.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_start`  in  1  single-cycle pulse (debounced upstream); start/pause/acknowledge.
- `btn_up`  in  1  single-cycle pulse; add STEP (IDLE only).
- `btn_down`  in  1  single-cycle pulse; subtract STEP (IDLE only).
- `btn_clear`  in  1  single-cycle pulse; return to IDLE with num=0.
- `num`  out  8  remaining seconds, registered; to digit decoder.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  high in DONE.
- `alarm`  out  1  in DONE, toggles on every tick; 0 in all other states.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- Reset values: num=0, running=paused=done=alarm=0, prescaler=0.
- Priority every cycle: rst > btn_clear > btn_start > btn_up > btn_down.
- btn_clear in any state: → IDLE, num=0, prescaler=0, alarm=0.
- IDLE:
  - btn_up: num = min(num+STEP, MAX_SEC).
  - btn_down: num = max(num−STEP, 0), no underflow wrap.
  - btn_start with num>0: → RUN, prescaler=0. btn_start with num==0: ignored.
- RUN:
  - Prescaler counts 0..TICK_DIV−1. The tick fires when count==TICK_DIV−1; the count then wraps to 0.
  - On tick, num−1. If that tick takes num from 1 to 0: → DONE.
  - btn_start: → PAUSE. A tick in the same cycle is still applied, including a 1→0 transition, which goes to DONE instead of PAUSE.
  - btn_up and btn_down are ignored.
- PAUSE:
  - Prescaler and num frozen.
  - btn_start: → RUN, resuming from the frozen prescaler count, so partial seconds are preserved.
  - btn_up and btn_down are ignored.
- DONE:
  - num held at 0. Prescaler keeps running to generate ticks; alarm toggles on each tick and starts at 1 on entry.
  - btn_start: → IDLE, num=0, alarm=0.
- Width rules:
  - The up/down add/subtract is computed in 9 bits before saturation, so values near 255 never wrap.
  - num never exceeds MAX_SEC.

## Timing
- Every output is registered and changes the cycle after its cause (button pulse or tick).
- Button → state/flag change: 1 cycle.
- Tick → num decrement visible: 1 cycle.
- Start → first decrement: exactly TICK_DIV cycles after the start pulse is sampled.
- DONE entry: done, alarm=1 and num=0 all appear on the same cycle.
- Reset mid-count: num, flags and prescaler are zero on the next cycle regardless of state.

## Structure
- Shared package `countdown_pkg`: state enum (IDLE/RUN/PAUSE/DONE), default constants MAX_SEC=239 and STEP=10.
- Sub-module `tick_prescaler`:
  - Parameter TICK_DIV; inputs clk, rst, enable, clear; output tick (1-cycle pulse).
  - Enable is high in RUN and DONE. Clear is asserted on entry to RUN from IDLE and on btn_clear.
- Top level holds the FSM, the num register and the alarm toggle.

## Test plan
- Use TICK_DIV=4 in all scenarios.
- Set and saturate:
  - From reset, 25× btn_up → num=230 after 23 presses, then 239 from press 24 onward.
  - From 0, btn_down → num stays 0.
- Run to zero:
  - num=20, btn_start → running=1; num=19 after 4 cycles.
  - After 80 cycles: num=0, done=1, alarm=1; alarm toggles every 4 cycles.
- Pause/resume:
  - In RUN, btn_start at prescaler count 2 → paused=1, num frozen for 50 cycles.
  - Second btn_start → next decrement 2 cycles after resume.
- Simultaneous events:
  - btn_start coincident with the 1→0 tick → DONE, not PAUSE.
  - btn_clear + btn_start in IDLE with num=30 → IDLE, num=0.
- Ignored inputs:
  - btn_start in IDLE with num=0 → state unchanged.
  - btn_up during RUN → num unaffected.
- Reset mid-operation:
  - rst asserted in RUN at num=57 → next cycle num=0, running=0.
  - First tick after restart arrives 4 cycles after the new btn_start.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and defaults for the countdown sequencer
// Contents: state_e (IDLE/RUN/PAUSE/DONE), default MAX_SEC/STEP, num width.
package countdown_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned NUM_W       = 8;
  localparam int unsigned DEF_MAX_SEC = 239;
  localparam int unsigned DEF_STEP    = 10;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk down to a one-cycle tick every TICK_DIV cycles
// Ports: clk, rst (sync, active-high), enable (count), clear (restart at 0),
//        tick (high for the cycle in which the count sits at TICK_DIV-1).
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count_q, count_d;

  // Clear wins over enable so a restart never emits a stale tick.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      if (count_q == LAST) begin
        tick    = 1'b1;
        count_d = '0;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - countdown sequencer: set, start/pause, tick down, alarm at zero
// Ports: clk, rst (sync, active-high); btn_start/btn_up/btn_down/btn_clear
//        single-cycle pulses; num (remaining seconds), running, paused, done,
//        alarm (blinks once per tick in DONE). All outputs are registered.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned MAX_SEC  = DEF_MAX_SEC,
  parameter int unsigned STEP     = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_clear,
  output logic [NUM_W-1:0] num,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic             alarm
);

  localparam logic [NUM_W:0] MAX9  = (NUM_W+1)'(MAX_SEC);
  localparam logic [NUM_W:0] STEP9 = (NUM_W+1)'(STEP);

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             alarm_q, alarm_d;
  logic             running_q, paused_q, done_q;

  logic             tick;
  logic             pre_en;
  logic             pre_clr;
  logic [NUM_W:0]   sum9;
  logic [NUM_W:0]   diff9;
  logic [NUM_W-1:0] num_up;
  logic [NUM_W-1:0] num_dn;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );

  // One extra bit of headroom so saturation is decided before truncation.
  always_comb begin
    sum9   = {1'b0, num_q} + STEP9;
    diff9  = {1'b0, num_q} - STEP9;
    num_up = (sum9 > MAX9) ? MAX9[NUM_W-1:0] : sum9[NUM_W-1:0];
    num_dn = ({1'b0, num_q} < STEP9) ? '0 : diff9[NUM_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    alarm_d = alarm_q;
    pre_clr = 1'b0;
    pre_en  = (state_q == S_RUN) || (state_q == S_DONE);

    if (btn_clear) begin
      state_d = S_IDLE;
      num_d   = '0;
      alarm_d = 1'b0;
      pre_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_start) begin
            if (num_q != '0) begin
              state_d = S_RUN;
              pre_clr = 1'b1;
            end
          end else if (btn_up) begin
            num_d = num_up;
          end else if (btn_down) begin
            num_d = num_dn;
          end
        end
        S_RUN: begin
          // A tick landing with a pause request is still applied; reaching
          // zero takes precedence over pausing.
          if (tick && (num_q != '0)) begin
            num_d = num_q - NUM_W'(1);
          end
          if (tick && (num_q == NUM_W'(1))) begin
            state_d = S_DONE;
            alarm_d = 1'b1;
          end else if (btn_start) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (btn_start) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          num_d = '0;
          if (btn_start) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
          end else if (tick) begin
            alarm_d = ~alarm_q;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      num_q     <= '0;
      alarm_q   <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      alarm_q   <= alarm_d;
      running_q <= (state_d == S_RUN);
      paused_q  <= (state_d == S_PAUSE);
      done_q    <= (state_d == S_DONE);
    end
  end

  assign num     = num_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule
